// File: rtl/decode_scoreboard_pkg.sv
// Shared register-file geometry and the decoded-instruction payload.
package decode_scoreboard_pkg;

  localparam int unsigned NUM_ARCH_REGS       = 32;
  localparam int unsigned ARCH_REG_INDEX_SIZE = 5;

  typedef struct packed {
    logic [ARCH_REG_INDEX_SIZE-1:0] rs1;
    logic [ARCH_REG_INDEX_SIZE-1:0] rs2;
    logic [ARCH_REG_INDEX_SIZE-1:0] rd;
    logic                           use_rs1;
    logic                           use_rs2;
    logic                           wr_rd;
  } dec_instr_t;

endpackage

// File: rtl/decode_scoreboard_pending.sv
// Pending-write table: one bit per architectural register, with writeback bypass on lookups.
module reg_pending_table
  import decode_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_WB = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      set_en_i,
  input  logic [ARCH_REG_INDEX_SIZE-1:0]            set_idx_i,
  input  logic [NUM_WB-1:0]                         clr_valid_i,
  input  logic [NUM_WB-1:0][ARCH_REG_INDEX_SIZE-1:0] clr_idx_i,
  input  logic [2:0][ARCH_REG_INDEX_SIZE-1:0]       rd_idx_i,
  output logic [2:0]                                busy_o
);

  logic [NUM_ARCH_REGS-1:0] pend_q;
  logic [NUM_ARCH_REGS-1:0] pend_d;
  logic [NUM_ARCH_REGS-1:0] wb_hit;
  logic [NUM_ARCH_REGS-1:0] pend_eff;

  // Decode all writeback ports into a per-register hit mask; duplicates collapse naturally.
  always_comb begin
    wb_hit = '0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (clr_valid_i[k]) wb_hit[clr_idx_i[k]] = 1'b1;
    end
  end

  assign pend_eff = pend_q & ~wb_hit;

  // Clear by writeback first, then apply the issue set so a new producer wins; x0 never pends.
  always_comb begin
    pend_d = pend_eff;
    if (set_en_i && (set_idx_i != '0)) pend_d[set_idx_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Bypassed lookups for rs1, rs2 and rd of the held instruction.
  always_comb begin
    busy_o = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      busy_o[i] = pend_eff[rd_idx_i[i]];
    end
  end

  // Pending vector register.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/decode_scoreboard.sv
// In-order issue scoreboard: one-entry holding register, hazard check, issue handshake, stall counter.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_WB      = 2,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      dec_valid,
  output logic                                      dec_ready,
  input  logic [ARCH_REG_INDEX_SIZE-1:0]            dec_rs1,
  input  logic [ARCH_REG_INDEX_SIZE-1:0]            dec_rs2,
  input  logic [ARCH_REG_INDEX_SIZE-1:0]            dec_rd,
  input  logic                                      dec_use_rs1,
  input  logic                                      dec_use_rs2,
  input  logic                                      dec_wr_rd,
  output logic                                      iss_valid,
  input  logic                                      iss_ready,
  output dec_instr_t                                iss_instr,
  input  logic [NUM_WB-1:0]                         wb_valid,
  input  logic [NUM_WB-1:0][ARCH_REG_INDEX_SIZE-1:0] wb_rd,
  output logic                                      stall_raw,
  output logic                                      stall_waw,
  output logic [STALL_CNT_W-1:0]                    stall_cnt
);

  logic                   held_q;
  logic                   held_d;
  dec_instr_t             instr_q;
  dec_instr_t             instr_d;
  dec_instr_t             dec_instr;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d;
  logic [2:0]             busy;
  logic                   raw;
  logic                   waw;
  logic                   issue;

  assign dec_instr = '{rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
                       use_rs1: dec_use_rs1, use_rs2: dec_use_rs2, wr_rd: dec_wr_rd};

  reg_pending_table #(.NUM_WB(NUM_WB)) u_pend (
    .clk         (clk),
    .rst         (rst),
    .set_en_i    (issue && instr_q.wr_rd),
    .set_idx_i   (instr_q.rd),
    .clr_valid_i (wb_valid),
    .clr_idx_i   (wb_rd),
    .rd_idx_i    ({instr_q.rd, instr_q.rs2, instr_q.rs1}),
    .busy_o      (busy)
  );

  // Hazard evaluation and handshake; depends only on held state, writebacks and iss_ready.
  always_comb begin
    raw       = (instr_q.use_rs1 && busy[0]) || (instr_q.use_rs2 && busy[1]);
    waw       = instr_q.wr_rd && busy[2];
    iss_valid = held_q && !raw && !waw;
    issue     = iss_valid && iss_ready;
    dec_ready = !held_q || issue;
    stall_raw = held_q && raw;
    stall_waw = held_q && waw;
    iss_instr = instr_q;
    stall_cnt = stall_cnt_q;
  end

  // Next state of the holding register and the saturating stall counter.
  always_comb begin
    held_d      = held_q;
    instr_d     = instr_q;
    stall_cnt_d = stall_cnt_q;
    if (dec_valid && dec_ready) begin
      held_d  = 1'b1;
      instr_d = dec_instr;
    end else if (issue) begin
      held_d = 1'b0;
    end
    if (held_q && !iss_valid && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q      <= 1'b0;
      instr_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      held_q      <= held_d;
      instr_q     <= instr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
